store_buffer_lsu: RTL and testbench

//  Load/store unit between the execute stage and Data_Memory. Buffers stores in an in-order

---
 rtl/store_buffer_lsu_if.sv | 29 ++
 rtl/store_buffer_lsu.sv | 119 +++++++++++
 tb/tb_store_buffer_lsu.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_lsu_if.sv
// Request/response and flush handshake between the execute stage and the store-buffered LSU.
interface store_buffer_lsu_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              flush_req;
  logic              flush_done;
  logic [CNT_W-1:0]  buf_count;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, flush_req,
    input  req_ready, rsp_valid, rsp_data, flush_done, buf_count
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, flush_req,
    output req_ready, rsp_valid, rsp_data, flush_done, buf_count
  );
endinterface

// File: rtl/store_buffer_lsu.sv
// Load/store unit: in-order store FIFO drained into a single memory port when idle,
// 1-cycle loads with youngest-match store-to-load forwarding, and drain-to-empty flush.
module store_buffer_lsu #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  store_buffer_lsu_if.slave   io_core,
  output logic                o_mem_read,
  output logic                o_mem_write,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  input  logic [DATA_W-1:0]   i_mem_rdata
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;

  logic              w_empty;
  logic              w_full;
  logic              w_req_ready;
  logic              w_accept;
  logic              w_enq;
  logic              w_load;
  logic              w_drain;
  logic              w_hit;
  logic [DATA_W-1:0] w_hit_data;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_req_ready = (r_state == StRun) && !w_full;
  assign w_accept    = io_core.req_valid && w_req_ready;
  assign w_enq       = w_accept && io_core.req_write;
  assign w_load      = w_accept && !io_core.req_write;
  // In RUN a drain only uses the port when no request claimed it this cycle.
  assign w_drain     = !w_empty && (!w_accept || (r_state == StFlush));

  // Scan oldest to youngest so the last match (youngest store) wins.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < r_count) && (r_addr[r_rptr + PTR_W'(i)] == io_core.req_addr)) begin
        w_hit      = 1'b1;
        w_hit_data = r_data[r_rptr + PTR_W'(i)];
      end
    end
  end

  always_comb begin
    o_mem_read  = w_load && !w_hit;
    o_mem_write = w_drain;
    o_mem_addr  = w_empty ? '0 : r_addr[r_rptr];
    o_mem_wdata = w_empty ? '0 : r_data[r_rptr];
    if (o_mem_read) begin
      o_mem_addr = io_core.req_addr;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StRun:   if (io_core.flush_req) w_state_next = StFlush;
      StFlush: if (w_empty)           w_state_next = StRun;
      default: w_state_next = StRun;
    endcase
  end

  assign io_core.req_ready  = w_req_ready;
  assign io_core.rsp_valid  = r_rsp_valid;
  assign io_core.rsp_data   = r_rsp_data;
  assign io_core.flush_done = (r_state == StFlush) && w_empty;
  assign io_core.buf_count  = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StRun;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_rsp_valid <= w_load;
      if (w_enq) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_drain) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_drain);
      if (w_load) begin
        r_rsp_data <= w_hit ? w_hit_data : i_mem_rdata;
      end
    end
  end

  // Entry contents need no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr[r_wptr] <= io_core.req_addr;
      r_data[r_wptr] <= io_core.req_wdata;
    end
  end
endmodule

// File: tb/tb_store_buffer_lsu.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_store_buffer_lsu;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } ent_t;

  logic       clk;
  logic       reset;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic [7:0] dmem [256];

  integer checks;
  integer errors;

  store_buffer_lsu_if #(.DEPTH(DEPTH), .ADDR_W(8), .DATA_W(8)) bus ();

  store_buffer_lsu #(.DEPTH(DEPTH), .ADDR_W(8), .DATA_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .io_core     (bus.slave),
    .o_mem_read  (mem_read),
    .o_mem_write (mem_write),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data_Memory: initialised to mem[a] = a, reset together with the LSU.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 8'(i);
    end else if (mem_write) begin
      dmem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = dmem[mem_addr];

  // Reference model state
  ent_t       q[$];
  bit         m_flush;
  logic [7:0] ref_mem [256];
  bit         m_rsp_v;
  logic [7:0] m_rsp_d;

  // Per-cycle expectations
  bit         e_ready, e_acc, e_mread, e_mwrite, e_done, e_rsp_v;
  logic [7:0] e_maddr, e_mwdata, e_load_val, e_rsp_d;
  logic [2:0] e_count;

  task automatic model_reset();
    q.delete();
    m_flush = 0;
    m_rsp_v = 0;
    m_rsp_d = 8'h00;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i);
  endtask

  task automatic model_eval();
    bit hit;
    hit        = 0;
    e_count    = 3'(q.size());
    e_ready    = !m_flush && (q.size() < DEPTH);
    e_acc      = bus.req_valid && e_ready;
    e_load_val = ref_mem[bus.req_addr];
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (!hit && q[i].a == bus.req_addr) begin
        hit        = 1;
        e_load_val = q[i].d;
      end
    end
    e_mread  = e_acc && !bus.req_write && !hit;
    e_mwrite = (q.size() > 0) && (!e_acc || m_flush);
    e_maddr  = e_mread ? bus.req_addr : ((q.size() > 0) ? q[0].a : 8'h00);
    e_mwdata = (q.size() > 0) ? q[0].d : 8'h00;
    e_done   = m_flush && (q.size() == 0);
    e_rsp_v  = m_rsp_v;
    e_rsp_d  = m_rsp_d;
  endtask

  task automatic model_commit(input bit w, input logic [7:0] a, input logic [7:0] d,
                              input bit f);
    bit load_now;
    load_now = e_acc && !w;
    if (e_mwrite) begin
      ref_mem[q[0].a] = q[0].d;
      void'(q.pop_front());
    end
    if (e_acc && w) q.push_back('{a: a, d: d});
    if (!m_flush && f) m_flush = 1;
    else if (m_flush && e_done) m_flush = 0;
    m_rsp_v = load_now;
    if (load_now) m_rsp_d = e_load_val;
  endtask

  // Drive one cycle's inputs away from the edge and compute expectations.
  task automatic drive(input bit v, input bit w, input logic [7:0] a, input logic [7:0] d,
                       input bit f);
    @(negedge clk);
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.flush_req = f;
    #1;
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit(bus.req_write, bus.req_addr, bus.req_wdata, bus.flush_req);
  endtask

  task automatic idle_cycle();
    drive(0, 0, 8'h00, 8'h00, 0);
    advance();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = 0; bus.req_wdata = 0;
    bus.flush_req = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.buf_count !== 3'd0) begin
      errors++; $display("FAIL reset_count got %0d exp 0", bus.buf_count);
    end
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 8'h00) begin
      errors++; $display("FAIL reset_rsp got %b/%h exp 0/00", bus.rsp_valid, bus.rsp_data);
    end
    checks++;
    if (bus.flush_done !== 1'b0 || mem_write !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl got done=%b mw=%b rdy=%b exp 0 0 1",
               bus.flush_done, mem_write, bus.req_ready);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_load_miss();
    drive(1, 0, 8'h10, 8'h00, 0);
    checks++;
    if (mem_read !== 1'b1 || mem_addr !== 8'h10) begin
      errors++; $display("FAIL miss_port got rd=%b addr=%h exp 1/10", mem_read, mem_addr);
    end
    advance();
    drive(0, 0, 8'h00, 8'h00, 0);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h10) begin
      errors++; $display("FAIL miss_rsp got %b/%h exp 1/10", bus.rsp_valid, bus.rsp_data);
    end
    advance();
    drive(0, 0, 8'h00, 8'h00, 0);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL miss_pulse got %b exp 0", bus.rsp_valid);
    end
    advance();
  endtask

  task automatic test_forward();
    drive(1, 1, 8'h20, 8'hAB, 0);
    advance();
    drive(1, 0, 8'h20, 8'h00, 0);
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      errors++; $display("FAIL fwd_port got rd=%b wr=%b exp 0/0", mem_read, mem_write);
    end
    advance();
    drive(0, 0, 8'h00, 8'h00, 0);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'hAB) begin
      errors++; $display("FAIL fwd_rsp got %b/%h exp 1/ab", bus.rsp_valid, bus.rsp_data);
    end
    checks++;
    if (mem_write !== 1'b1 || mem_addr !== 8'h20 || mem_wdata !== 8'hAB) begin
      errors++;
      $display("FAIL fwd_drain got wr=%b %h/%h exp 1 20/ab", mem_write, mem_addr, mem_wdata);
    end
    advance();
  endtask

  task automatic test_youngest();
    drive(1, 1, 8'h30, 8'h01, 0); advance();
    drive(1, 1, 8'h30, 8'h02, 0); advance();
    drive(1, 0, 8'h30, 8'h00, 0); advance();
    drive(0, 0, 8'h00, 8'h00, 0);
    checks++;
    if (bus.rsp_data !== 8'h02) begin
      errors++; $display("FAIL young_rsp got %h exp 02", bus.rsp_data);
    end
    checks++;
    if (mem_write !== 1'b1 || mem_addr !== 8'h30 || mem_wdata !== 8'h01) begin
      errors++;
      $display("FAIL young_drain1 got %b %h/%h exp 1 30/01", mem_write, mem_addr, mem_wdata);
    end
    advance();
    drive(0, 0, 8'h00, 8'h00, 0);
    checks++;
    if (mem_write !== 1'b1 || mem_wdata !== 8'h02) begin
      errors++; $display("FAIL young_drain2 got %b %h exp 1 02", mem_write, mem_wdata);
    end
    advance();
    drive(0, 0, 8'h00, 8'h00, 0);
    checks++;
    if (bus.buf_count !== 3'd0 || mem_write !== 1'b0) begin
      errors++; $display("FAIL young_empty got cnt=%0d wr=%b exp 0/0", bus.buf_count, mem_write);
    end
    advance();
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 8'(8'h40 + i), 8'(8'h50 + i), 0);
      checks++;
      if (bus.req_ready !== 1'b1) begin
        errors++; $display("FAIL full_fill%0d got rdy=%b exp 1", i, bus.req_ready);
      end
      advance();
    end
    drive(1, 1, 8'h44, 8'h54, 0);
    checks++;
    if (bus.buf_count !== 3'd4 || bus.req_ready !== 1'b0) begin
      errors++; $display("FAIL full_stall got cnt=%0d rdy=%b exp 4/0", bus.buf_count, bus.req_ready);
    end
    checks++;
    if (mem_write !== 1'b1 || mem_addr !== 8'h40 || mem_wdata !== 8'h50) begin
      errors++;
      $display("FAIL full_drain got %b %h/%h exp 1 40/50", mem_write, mem_addr, mem_wdata);
    end
    advance();
    drive(1, 1, 8'h44, 8'h54, 0);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.buf_count !== 3'd3 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL full_accept5 got rdy=%b cnt=%0d wr=%b exp 1/3/0",
               bus.req_ready, bus.buf_count, mem_write);
    end
    advance();
    for (int n = 0; n < 10 && q.size() > 0; n++) idle_cycle();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 8'(8'h60 + i), 8'(8'h70 + i), 0);
      advance();
    end
    drive(0, 0, 8'h00, 8'h00, 1);
    checks++;
    if (mem_write !== 1'b1 || mem_addr !== 8'h60) begin
      errors++; $display("FAIL flush_d1 got %b %h exp 1 60", mem_write, mem_addr);
    end
    advance();
    for (int i = 1; i < 3; i++) begin
      drive(1, 0, 8'h61, 8'h00, 1);
      checks++;
      if (bus.req_ready !== 1'b0 || mem_write !== 1'b1 || mem_addr !== 8'(8'h60 + i) ||
          bus.flush_done !== 1'b0 || mem_read !== 1'b0) begin
        errors++;
        $display("FAIL flush_d%0d got rdy=%b wr=%b addr=%h done=%b rd=%b", i + 1,
                 bus.req_ready, mem_write, mem_addr, bus.flush_done, mem_read);
      end
      advance();
    end
    drive(0, 0, 8'h00, 8'h00, 0);
    checks++;
    if (bus.flush_done !== 1'b1 || mem_write !== 1'b0 || bus.buf_count !== 3'd0) begin
      errors++;
      $display("FAIL flush_done got done=%b wr=%b cnt=%0d exp 1/0/0",
               bus.flush_done, mem_write, bus.buf_count);
    end
    advance();
    drive(0, 0, 8'h00, 8'h00, 0);
    checks++;
    if (bus.flush_done !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL flush_exit got done=%b rdy=%b exp 0/1", bus.flush_done, bus.req_ready);
    end
    advance();
    // Empty flush: request at t, done at t+1.
    drive(0, 0, 8'h00, 8'h00, 1);
    advance();
    drive(0, 0, 8'h00, 8'h00, 0);
    checks++;
    if (bus.flush_done !== 1'b1) begin
      errors++; $display("FAIL flush_empty got done=%b exp 1", bus.flush_done);
    end
    advance();
    idle_cycle();
  endtask

  task automatic test_reset_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 8'(8'h90 + i), 8'(8'hA0 + i), 0);
      advance();
    end
    drive(0, 0, 8'h00, 8'h00, 1);
    advance();
    drive(0, 0, 8'h00, 8'h00, 0);
    reset = 1'b1;
    #1;
    checks++;
    if (mem_write !== 1'b0 || bus.buf_count !== 3'd0 || bus.flush_done !== 1'b0 ||
        bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_flush got wr=%b cnt=%0d done=%b rdy=%b rv=%b exp 0/0/0/1/0",
               mem_write, bus.buf_count, bus.flush_done, bus.req_ready, bus.rsp_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int n = 0; n < 4; n++) begin
      drive(0, 0, 8'h00, 8'h00, 0);
      checks++;
      if (bus.flush_done !== 1'b0 || mem_write !== 1'b0) begin
        errors++; $display("FAIL rst_after%0d got done=%b wr=%b exp 0/0", n, bus.flush_done, mem_write);
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
            8'(8'h80 + $urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 99) < 3);
      checks++;
      if (mem_read !== e_mread || mem_write !== e_mwrite) begin
        errors++;
        $display("FAIL rnd_ctl[%0d] got rd=%b wr=%b exp %b/%b", n, mem_read, mem_write,
                 e_mread, e_mwrite);
      end
      checks++;
      if (mem_addr !== e_maddr || mem_wdata !== e_mwdata) begin
        errors++;
        $display("FAIL rnd_bus[%0d] got %h/%h exp %h/%h", n, mem_addr, mem_wdata,
                 e_maddr, e_mwdata);
      end
      checks++;
      if (bus.req_ready !== e_ready || bus.buf_count !== e_count ||
          bus.flush_done !== e_done) begin
        errors++;
        $display("FAIL rnd_state[%0d] got rdy=%b cnt=%0d done=%b exp %b/%0d/%b", n,
                 bus.req_ready, bus.buf_count, bus.flush_done, e_ready, e_count, e_done);
      end
      checks++;
      if (bus.rsp_valid !== e_rsp_v || (e_rsp_v && bus.rsp_data !== e_rsp_d)) begin
        errors++;
        $display("FAIL rnd_rsp[%0d] got %b/%h exp %b/%h", n, bus.rsp_valid, bus.rsp_data,
                 e_rsp_v, e_rsp_d);
      end
      advance();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    test_reset();
    test_load_miss();
    test_forward();
    test_youngest();
    test_full();
    test_flush();
    test_reset_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
